pipe_stage_buf: RTL and testbench

Parametrised, handshaked pipeline stage register for inter-stage boundaries (IF/ID, ID/EX, …) of the CPU pipeline. It replaces hand-written stall/flush stage registers with a valid/ready interface. An optional two-entry skid buffer registers the upstream ready path. Payload is opaque; callers pack pc, instruction and sideband bits into `in_data`.

---
 rtl/pipe_pkg.sv | 12 +
 rtl/pipe_stage_buf.sv | 106 ++++++++++
 tb/tb_pipe_stage_buf.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared types for the pipeline stage buffers: occupancy state and default payload width.
package pipe_pkg;

   localparam int PIPE_DATA_W = 96;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } pipe_occ_e;

endpackage

// File: rtl/pipe_stage_buf.sv
// Valid/ready pipeline stage register; a beat accepted on edge N is on out_data after edge N.
// SKID=1 adds a second entry so in_ready comes from a flop; SKID=0 passes out_ready through to in_ready.
module pipe_stage_buf
   import pipe_pkg::*;
#(
   parameter int DATA_W = PIPE_DATA_W,
   parameter int SKID   = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy
);

   pipe_occ_e         state_q, state_d;
   logic [DATA_W-1:0] main_q, main_d;
   logic [DATA_W-1:0] skid_q, skid_d;
   logic              in_hs, out_hs;

   assign in_hs     = in_valid & in_ready;
   assign out_hs    = out_valid & out_ready;
   assign out_valid = (state_q != EMPTY);
   assign out_data  = main_q;
   assign occupancy = state_q;

   // Empty entries are kept at zero so out_data needs no masking.
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      case (state_q)
         EMPTY: begin
            if (in_hs) begin
               state_d = ONE;
               main_d  = in_data;
            end
         end
         ONE: begin
            if (in_hs && out_hs) begin
               main_d = in_data;
            end else if (in_hs) begin
               if (SKID != 0) begin
                  state_d = FULL;
                  skid_d  = in_data;
               end
            end else if (out_hs) begin
               state_d = EMPTY;
               main_d  = '0;
            end
         end
         FULL: begin
            if (out_hs) begin
               state_d = ONE;
               main_d  = skid_q;
               skid_d  = '0;
            end
         end
         default: begin
            state_d = EMPTY;
            main_d  = '0;
            skid_d  = '0;
         end
      endcase
      if (flush) begin
         state_d = EMPTY;
         main_d  = '0;
         skid_d  = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

   generate
      if (SKID != 0) begin : g_skid
         logic rdy_q;
         // Mirrors state_q != FULL, held in its own flop to cut the out_ready path.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               rdy_q <= 1'b1;
            end else begin
               rdy_q <= (state_d != FULL);
            end
         end
         assign in_ready = rdy_q;
      end else begin : g_noskid
         assign in_ready = ~out_valid | out_ready;
      end
   endgenerate

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: directed vector table, async reset sequence, and a randomized run
// of four configurations (SKID 1/0 x DATA_W 96/8) against a list-based reference model.
module tb_pipe_stage_buf;

   localparam logic [3:0] SKID_MASK = 4'b0101;
   localparam int         N_RAND    = 2500;

   logic        clk = 1'b0;
   logic        rst;
   logic        fl[4], iv[4], ir[4], ordy[4], ov[4];
   logic [1:0]  occ[4];
   logic [95:0] id96[2], od96[2];
   logic [7:0]  id8[2], od8[2];

   always #5 clk = ~clk;

   pipe_stage_buf #(.DATA_W(96), .SKID(1)) u_s1_w96 (
      .clk(clk), .rst(rst), .flush(fl[0]), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id96[0]),
      .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od96[0]), .occupancy(occ[0]));
   pipe_stage_buf #(.DATA_W(96), .SKID(0)) u_s0_w96 (
      .clk(clk), .rst(rst), .flush(fl[1]), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id96[1]),
      .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od96[1]), .occupancy(occ[1]));
   pipe_stage_buf #(.DATA_W(8), .SKID(1)) u_s1_w8 (
      .clk(clk), .rst(rst), .flush(fl[2]), .in_valid(iv[2]), .in_ready(ir[2]), .in_data(id8[0]),
      .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(od8[0]), .occupancy(occ[2]));
   pipe_stage_buf #(.DATA_W(8), .SKID(0)) u_s0_w8 (
      .clk(clk), .rst(rst), .flush(fl[3]), .in_valid(iv[3]), .in_ready(ir[3]), .in_data(id8[1]),
      .out_valid(ov[3]), .out_ready(ordy[3]), .out_data(od8[1]), .occupancy(occ[3]));

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [95:0] act_data(input int i);
      case (i)
         0:       act_data = od96[0];
         1:       act_data = od96[1];
         2:       act_data = {88'b0, od8[0]};
         default: act_data = {88'b0, od8[1]};
      endcase
   endfunction

   task automatic set_data(input int i, input logic [95:0] d);
      case (i)
         0:       id96[0] = d;
         1:       id96[1] = d;
         2:       id8[0]  = d[7:0];
         default: id8[1]  = d[7:0];
      endcase
   endtask

   task automatic idle_all();
      for (int i = 0; i < 4; i++) begin
         fl[i]   = 1'b0;
         iv[i]   = 1'b0;
         ordy[i] = 1'b0;
         set_data(i, '0);
      end
   endtask

   typedef struct {
      int          inst;
      logic        f;
      logic        v;
      logic [95:0] d;
      logic        r;
      logic        e_ir;
      logic        e_ov;
      logic [95:0] e_od;
      logic [1:0]  e_occ;
   } vec_t;

   function automatic vec_t mk(input int inst, input logic f, input logic v, input logic [95:0] d,
                               input logic r, input logic e_ir, input logic e_ov,
                               input logic [95:0] e_od, input logic [1:0] e_occ);
      vec_t x;
      x.inst = inst; x.f = f; x.v = v; x.d = d; x.r = r;
      x.e_ir = e_ir; x.e_ov = e_ov; x.e_od = e_od; x.e_occ = e_occ;
      return x;
   endfunction

   // Reference model: an ordered list of held beats per instance (oldest first).
   logic [95:0] m_ent[4][2];
   int          m_cnt[4];
   logic        m_ihs[4], m_ohs[4];
   logic [95:0] m_din[4];

   vec_t tbl[23];

   initial begin
      //             inst f  v  data      rdy  ir ov out_data occ
      tbl[0]  = mk(0, 0, 1, 96'h1,  1,  1, 0, 96'h0,  0);
      tbl[1]  = mk(0, 0, 1, 96'h2,  1,  1, 1, 96'h1,  1);
      tbl[2]  = mk(0, 0, 1, 96'h3,  1,  1, 1, 96'h2,  1);
      tbl[3]  = mk(0, 0, 0, 96'h0,  1,  1, 1, 96'h3,  1);
      tbl[4]  = mk(0, 0, 1, 96'hA,  0,  1, 0, 96'h0,  0);
      tbl[5]  = mk(0, 0, 1, 96'hB,  0,  1, 1, 96'hA,  1);
      tbl[6]  = mk(0, 0, 1, 96'hC,  0,  0, 1, 96'hA,  2);
      tbl[7]  = mk(0, 0, 1, 96'hC,  1,  0, 1, 96'hA,  2);
      tbl[8]  = mk(0, 0, 1, 96'hC,  1,  1, 1, 96'hB,  1);
      tbl[9]  = mk(0, 0, 0, 96'h0,  1,  1, 1, 96'hC,  1);
      tbl[10] = mk(0, 0, 1, 96'h11, 0,  1, 0, 96'h0,  0);
      tbl[11] = mk(0, 0, 1, 96'h12, 0,  1, 1, 96'h11, 1);
      tbl[12] = mk(0, 1, 1, 96'hD,  0,  0, 1, 96'h11, 2);
      tbl[13] = mk(0, 0, 0, 96'h0,  1,  1, 0, 96'h0,  0);
      tbl[14] = mk(0, 0, 1, 96'h21, 0,  1, 0, 96'h0,  0);
      tbl[15] = mk(0, 1, 1, 96'hD,  1,  1, 1, 96'h21, 1);
      tbl[16] = mk(0, 0, 0, 96'h0,  1,  1, 0, 96'h0,  0);
      tbl[17] = mk(1, 0, 1, 96'h5,  0,  1, 0, 96'h0,  0);
      tbl[18] = mk(1, 0, 1, 96'h6,  0,  0, 1, 96'h5,  1);
      tbl[19] = mk(1, 0, 1, 96'h6,  0,  0, 1, 96'h5,  1);
      tbl[20] = mk(1, 0, 1, 96'h6,  1,  1, 1, 96'h5,  1);
      tbl[21] = mk(1, 0, 0, 96'h0,  1,  1, 1, 96'h6,  1);
      tbl[22] = mk(1, 0, 0, 96'h0,  0,  1, 0, 96'h0,  0);

      rst = 1'b1;
      idle_all();
      #1;
      check("reset in_ready", {95'b0, ir[0]}, 96'h1);
      check("reset out_valid", {95'b0, ov[0]}, 96'h0);
      check("reset occupancy", {94'b0, occ[0]}, 96'h0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      for (int k = 0; k < 23; k++) begin
         int i;
         @(negedge clk);
         idle_all();
         i       = tbl[k].inst;
         fl[i]   = tbl[k].f;
         iv[i]   = tbl[k].v;
         ordy[i] = tbl[k].r;
         set_data(i, tbl[k].d);
         #1;
         check($sformatf("vec%0d in_ready", k),  {95'b0, ir[i]},  {95'b0, tbl[k].e_ir});
         check($sformatf("vec%0d out_valid", k), {95'b0, ov[i]},  {95'b0, tbl[k].e_ov});
         check($sformatf("vec%0d out_data", k),  act_data(i),     tbl[k].e_od);
         check($sformatf("vec%0d occupancy", k), {94'b0, occ[i]}, {94'b0, tbl[k].e_occ});
      end

      // Asynchronous reset while FULL, then first beat after release.
      @(negedge clk);
      idle_all();
      iv[0] = 1'b1; set_data(0, 96'h31);
      @(negedge clk);
      set_data(0, 96'h32);
      @(negedge clk);
      idle_all();
      #1;
      check("pre-rst occupancy", {94'b0, occ[0]}, 96'h2);
      check("pre-rst in_ready", {95'b0, ir[0]}, 96'h0);
      #2 rst = 1'b1;
      #1;
      check("async rst out_valid", {95'b0, ov[0]}, 96'h0);
      check("async rst out_data", act_data(0), 96'h0);
      check("async rst occupancy", {94'b0, occ[0]}, 96'h0);
      check("async rst in_ready", {95'b0, ir[0]}, 96'h1);
      @(negedge clk);
      rst = 1'b0;
      iv[0] = 1'b1; ordy[0] = 1'b1; set_data(0, 96'h41);
      #1;
      check("post-rst in_ready", {95'b0, ir[0]}, 96'h1);
      check("post-rst out_valid before edge", {95'b0, ov[0]}, 96'h0);
      @(posedge clk);
      #1;
      check("post-rst out_valid", {95'b0, ov[0]}, 96'h1);
      check("post-rst out_data", act_data(0), 96'h41);
      check("post-rst occupancy", {94'b0, occ[0]}, 96'h1);

      // Randomized run on all four configurations.
      @(negedge clk);
      idle_all();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;

      for (int c = 0; c < N_RAND; c++) begin
         int rdy_pct;
         @(negedge clk);
         rdy_pct = ((c / 400) % 2 == 0) ? 80 : 30;
         for (int i = 0; i < 4; i++) begin
            logic [95:0] d;
            d = {$urandom, $urandom, $urandom};
            if (i >= 2) d = d & 96'hFF;
            fl[i]   = ($urandom_range(0, 99) < 3);
            iv[i]   = ($urandom_range(0, 99) < 70);
            ordy[i] = ($urandom_range(0, 99) < rdy_pct);
            set_data(i, d);
            m_din[i] = d;
         end
         #1;
         for (int i = 0; i < 4; i++) begin
            logic        e_ir;
            logic [95:0] e_od;
            e_ir = SKID_MASK[i] ? (m_cnt[i] < 2) : ((m_cnt[i] == 0) || ordy[i]);
            e_od = (m_cnt[i] > 0) ? m_ent[i][0] : 96'h0;
            check($sformatf("rnd i%0d c%0d in_ready", i, c),  {95'b0, ir[i]}, {95'b0, e_ir});
            check($sformatf("rnd i%0d c%0d out_valid", i, c), {95'b0, ov[i]}, {95'b0, (m_cnt[i] > 0)});
            check($sformatf("rnd i%0d c%0d out_data", i, c),  act_data(i), e_od);
            check($sformatf("rnd i%0d c%0d occupancy", i, c), {94'b0, occ[i]}, 96'(m_cnt[i]));
            m_ihs[i] = iv[i] & e_ir;
            m_ohs[i] = (m_cnt[i] > 0) & ordy[i];
         end
         @(posedge clk);
         for (int i = 0; i < 4; i++) begin
            if (fl[i]) begin
               m_cnt[i] = 0;
            end else begin
               if (m_ohs[i]) begin
                  m_ent[i][0] = m_ent[i][1];
                  m_cnt[i]--;
               end
               if (m_ihs[i]) begin
                  m_ent[i][m_cnt[i]] = m_din[i];
                  m_cnt[i]++;
               end
            end
         end
      end

      @(negedge clk);
      idle_all();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
